// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if
// Bundles the sequencer's datapath-facing signals.
//   master : the datapath side. It drives Run/OP/Zero/MemReady and observes the control strobes.
//   slave  : the sequencer side. It observes the inputs and drives the strobes, State,
//            InstrCount and the sticky Illegal/Timeout flags.
// Parameter COUNT_W sets the width of the retired-instruction counter.
interface mips_multicycle_control_if #(
  parameter int COUNT_W = 16
);
  logic               Run;
  logic [5:0]         OP;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               Link;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUOp;
  logic [1:0]         PCSource;
  logic [3:0]         State;
  logic [COUNT_W-1:0] InstrCount;
  logic               Illegal;
  logic               Timeout;

  modport master (
    output Run, OP, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           Link, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, InstrCount, Illegal, Timeout
  );

  modport slave (
    input  Run, OP, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           Link, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, InstrCount, Illegal, Timeout
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Moore-style multicycle sequencer for the MIPS core. It steps a shared ALU/memory datapath
// through fetch, decode, execute, memory and writeback states. It stalls on MemReady and
// aborts to IDLE when a memory wait exceeds WAIT_MAX cycles. It also counts retired
// instructions and flags undecoded opcodes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mips_multicycle_control_if.slave. Carries Run/OP/Zero/MemReady in and the
//           strobes, State, InstrCount, Illegal and Timeout out.
// Parameters: COUNT_W (counter width), WAIT_MAX (memory wait limit, 0 = no limit).
// Optional feature: define MC_JUMP_EN to decode J (0x02) and JAL (0x03) into the JUMP state.
module mips_multicycle_control #(
  parameter int COUNT_W  = 16,
  parameter int WAIT_MAX = 15
) (
  input logic                      clk,
  input logic                      reset,
  mips_multicycle_control_if.slave bus
);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } stateT;

  typedef struct packed {
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       link;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
  } ctrlT;

  stateT              state_q, state_d;
  ctrlT               ctrl_q;
  logic [COUNT_W-1:0] count_q;
  logic [WAIT_W-1:0]  waitCnt_q;
  logic               illegal_q, timeout_q;
  logic               retire, runStart, illegalSet, timeoutSet, memWait;

  // State-only strobes. These are registered from the next state, so they line up with
  // state_q and drop together with it on reset. In the default build nothing sets link,
  // so Link stays 0.
  function automatic ctrlT decodeState(stateT s, logic [5:0] op);
    ctrlT c;
    c = '0;
    case (s)
      FETCH:     begin c.memRead = 1'b1; c.aluSrcB = 2'd1; c.aluOp = 3'b100; end
      DECODE:    begin c.aluSrcB = 2'd3; c.aluOp = 3'b100; end
      MEM_ADDR:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = 3'b011; end
      MEM_READ:  begin c.iorD = 1'b1; c.memRead = 1'b1; end
      MEM_WB:    begin c.memtoReg = 1'b1; c.regWrite = 1'b1; end
      MEM_WRITE: begin c.iorD = 1'b1; c.memWrite = 1'b1; end
      R_EXEC:    begin c.aluSrcA = 1'b1; c.aluOp = 3'b111; end
      R_WB:      begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      I_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'd2;
        c.aluOp   = (op == 6'h0d) ? 3'b101 : (op == 6'h0f) ? 3'b110 : 3'b100;
      end
      I_WB:      c.regWrite = 1'b1;
      BRANCH:    begin c.aluSrcA = 1'b1; c.aluOp = 3'b001; c.pcSource = 2'd1; end
`ifdef MC_JUMP_EN
      JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 2'd2;
        c.regWrite = (op == 6'h03);
        c.link     = (op == 6'h03);
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  // Next-state logic. The memory wait checks run after the case statement, so a timeout
  // overrides the "hold" decision in any of the three waiting states.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    runStart   = 1'b0;
    illegalSet = 1'b0;
    timeoutSet = 1'b0;
    memWait    = 1'b0;
    case (state_q)
      IDLE: if (bus.Run) begin state_d = FETCH; runStart = 1'b1; end
      FETCH: if (bus.MemReady) state_d = DECODE; else memWait = 1'b1;
      DECODE: begin
        case (bus.OP)
          6'h00:               state_d = R_EXEC;
          6'h08, 6'h0d, 6'h0f: state_d = I_EXEC;
          6'h23, 6'h2b:        state_d = MEM_ADDR;
          6'h04, 6'h05:        state_d = BRANCH;
`ifdef MC_JUMP_EN
          6'h02, 6'h03:        state_d = JUMP;
`endif
          default: begin state_d = IDLE; illegalSet = 1'b1; end
        endcase
      end
      MEM_ADDR: state_d = (bus.OP == 6'h2b) ? MEM_WRITE : MEM_READ;
      MEM_READ: if (bus.MemReady) state_d = MEM_WB; else memWait = 1'b1;
      MEM_WB: begin state_d = FETCH; retire = 1'b1; end
      MEM_WRITE: begin
        if (bus.MemReady) begin state_d = FETCH; retire = 1'b1; end
        else memWait = 1'b1;
      end
      R_EXEC: state_d = R_WB;
      R_WB:   begin state_d = FETCH; retire = 1'b1; end
      I_EXEC: state_d = I_WB;
      I_WB:   begin state_d = FETCH; retire = 1'b1; end
      BRANCH: begin state_d = FETCH; retire = 1'b1; end
`ifdef MC_JUMP_EN
      JUMP:   begin state_d = FETCH; retire = 1'b1; end
`endif
      default: state_d = IDLE;
    endcase
    // This is the cycle in which the wait count would reach WAIT_MAX while the memory
    // is still busy. A ready response in this same cycle completes normally.
    if (memWait && (WAIT_MAX > 0) && (int'(waitCnt_q) >= WAIT_MAX - 1)) begin
      state_d    = IDLE;
      timeoutSet = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      count_q   <= '0;
      waitCnt_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decodeState(state_d, bus.OP);
      if (retire) count_q <= count_q + COUNT_W'(1);
      if (state_d != state_q) waitCnt_q <= '0;
      else if (memWait)       waitCnt_q <= waitCnt_q + WAIT_W'(1);
      if (runStart) begin
        illegal_q <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (illegalSet) illegal_q <= 1'b1;
      if (timeoutSet) timeout_q <= 1'b1;
    end
  end

  // The fetch completion strobes and the branch decision depend on this cycle's inputs.
  // They are therefore combined with the registered state-only strobes.
  assign bus.PCWrite    = ctrl_q.pcWrite
                        | ((state_q == FETCH) & bus.MemReady)
                        | ((state_q == BRANCH) & (((bus.OP == 6'h04) & bus.Zero) |
                                                  ((bus.OP == 6'h05) & ~bus.Zero)));
  assign bus.IRWrite    = (state_q == FETCH) & bus.MemReady;
  assign bus.IorD       = ctrl_q.iorD;
  assign bus.MemRead    = ctrl_q.memRead;
  assign bus.MemWrite   = ctrl_q.memWrite;
  assign bus.MemtoReg   = ctrl_q.memtoReg;
  assign bus.RegDst     = ctrl_q.regDst;
  assign bus.RegWrite   = ctrl_q.regWrite;
  assign bus.Link       = ctrl_q.link;
  assign bus.ALUSrcA    = ctrl_q.aluSrcA;
  assign bus.ALUSrcB    = ctrl_q.aluSrcB;
  assign bus.ALUOp      = ctrl_q.aluOp;
  assign bus.PCSource   = ctrl_q.pcSource;
  assign bus.State      = state_q;
  assign bus.InstrCount = count_q;
  assign bus.Illegal    = illegal_q;
  assign bus.Timeout    = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// Directed scoreboard bench for mips_multicycle_control with WAIT_MAX=4.
// For each cycle, the stimulus process queues the output vector expected from the hand-given
// state and the sticky and count values. A negedge monitor pops and compares those entries.
module tb_mips_multicycle_control;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_multicycle_control_if #(.COUNT_W(CW)) busIf ();

  mips_multicycle_control #(.COUNT_W(CW), .WAIT_MAX(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (busIf.slave)
  );

  typedef struct {
    int          cycle;
    string       name;
    logic [38:0] exp;
  } expT;

  expT           sbQ[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] expCnt;
  logic          expIll, expTo;

  // Output table written out by state, with the input-dependent PCWrite/IRWrite terms.
  function automatic logic [38:0] expectedVector(input logic [3:0] st, input logic [5:0] op,
                                                 input logic zero, input logic mr,
                                                 input logic [CW-1:0] cnt, input logic ill,
                                                 input logic to);
    logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, lnk, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, lnk, asa} = '0;
    asb = 2'd0; pcs = 2'd0; aop = 3'd0;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'd1; aop = 3'b100; pcw = mr; irw = mr; end
      4'd2:  begin asb = 2'd3; aop = 3'b100; end
      4'd3:  begin asa = 1; asb = 2'd2; aop = 3'b011; end
      4'd4:  begin iord = 1; mrd = 1; end
      4'd5:  begin m2r = 1; rw = 1; end
      4'd6:  begin iord = 1; mwr = 1; end
      4'd7:  begin asa = 1; aop = 3'b111; end
      4'd8:  begin rdst = 1; rw = 1; end
      4'd9:  begin
        asa = 1; asb = 2'd2;
        aop = (op == 6'h0d) ? 3'b101 : (op == 6'h0f) ? 3'b110 : 3'b100;
      end
      4'd10: rw = 1;
      4'd11: begin
        asa = 1; aop = 3'b001; pcs = 2'd1;
        pcw = ((op == 6'h04) && zero) || ((op == 6'h05) && !zero);
      end
      4'd12: begin pcw = 1; pcs = 2'd2; rw = (op == 6'h03); lnk = (op == 6'h03); end
      default: ;
    endcase
    return {st, pcw, iord, mrd, mwr, irw, m2r, rdst, rw, lnk, asa, asb, aop, pcs, cnt, ill, to};
  endfunction

  function automatic logic [38:0] actualVector();
    return {busIf.State, busIf.PCWrite, busIf.IorD, busIf.MemRead, busIf.MemWrite,
            busIf.IRWrite, busIf.MemtoReg, busIf.RegDst, busIf.RegWrite, busIf.Link,
            busIf.ALUSrcA, busIf.ALUSrcB, busIf.ALUOp, busIf.PCSource, busIf.InstrCount,
            busIf.Illegal, busIf.Timeout};
  endfunction

  task automatic checkOutput(input expT e);
    logic [38:0] act;
    act = actualVector();
    vectors++;
    if (act !== e.exp) begin
      miscompares++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", e.name, e.cycle, act, e.exp);
    end
  endtask

  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cycle <= cyc) begin
      expT e;
      e = sbQ.pop_front();
      checkOutput(e);
    end
  end

  // Drive one cycle of inputs, queue the expected outputs for that cycle, and then move on
  // to just after the next rising edge.
  task automatic applyStimulus(input string name, input logic run, input logic [5:0] op,
                               input logic zero, input logic mr, input logic [3:0] st);
    expT e;
    busIf.Run      = run;
    busIf.OP       = op;
    busIf.Zero     = zero;
    busIf.MemReady = mr;
    e.cycle = cyc;
    e.name  = name;
    e.exp   = expectedVector(st, op, zero, mr, expCnt, expIll, expTo);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetchDecode(input string name, input logic [5:0] op);
    applyStimulus({name, "Fetch"}, 1'b0, op, 1'b0, 1'b1, 4'd1);
    applyStimulus({name, "Decode"}, 1'b0, op, 1'b0, 1'b0, 4'd2);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    busIf.Run = 1'b0; busIf.OP = 6'h00; busIf.Zero = 1'b0; busIf.MemReady = 1'b0;
    expCnt = '0; expIll = 1'b0; expTo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("resetState", 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    applyStimulus("idleRun", 1'b1, 6'h00, 1'b0, 1'b0, 4'd0);
    applyStimulus("fetchHold", 1'b0, 6'h00, 1'b0, 1'b0, 4'd1);
    reset = 1'b0;
    applyStimulus("resetMidFetch", 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    applyStimulus("idleRunAgain", 1'b1, 6'h00, 1'b0, 1'b0, 4'd0);

    // R-type: 1,2,7,8 then retire
    fetchDecode("rType", 6'h00);
    applyStimulus("rExec", 1'b0, 6'h00, 1'b0, 1'b0, 4'd7);
    applyStimulus("rWb", 1'b0, 6'h00, 1'b0, 1'b0, 4'd8);
    expCnt++;

    // LW with three wait cycles in MEM_READ, ready on the last allowed cycle
    fetchDecode("lw", 6'h23);
    applyStimulus("lwAddr", 1'b0, 6'h23, 1'b0, 1'b0, 4'd3);
    for (int i = 0; i < 3; i++) applyStimulus("lwWait", 1'b0, 6'h23, 1'b0, 1'b0, 4'd4);
    applyStimulus("lwReady", 1'b0, 6'h23, 1'b0, 1'b1, 4'd4);
    applyStimulus("lwWb", 1'b0, 6'h23, 1'b0, 1'b0, 4'd5);
    expCnt++;

    // SW with one wait cycle
    fetchDecode("sw", 6'h2b);
    applyStimulus("swAddr", 1'b0, 6'h2b, 1'b0, 1'b0, 4'd3);
    applyStimulus("swWait", 1'b0, 6'h2b, 1'b0, 1'b0, 4'd6);
    applyStimulus("swReady", 1'b0, 6'h2b, 1'b0, 1'b1, 4'd6);
    expCnt++;

    // ORI and LUI
    fetchDecode("ori", 6'h0d);
    applyStimulus("oriExec", 1'b0, 6'h0d, 1'b0, 1'b0, 4'd9);
    applyStimulus("oriWb", 1'b0, 6'h0d, 1'b0, 1'b0, 4'd10);
    expCnt++;
    fetchDecode("lui", 6'h0f);
    applyStimulus("luiExec", 1'b0, 6'h0f, 1'b0, 1'b0, 4'd9);
    applyStimulus("luiWb", 1'b0, 6'h0f, 1'b0, 1'b0, 4'd10);
    expCnt++;

    // Branches
    fetchDecode("beq", 6'h04);
    applyStimulus("beqTaken", 1'b0, 6'h04, 1'b1, 1'b0, 4'd11);
    expCnt++;
    fetchDecode("bne", 6'h05);
    applyStimulus("bneNotTaken", 1'b0, 6'h05, 1'b1, 1'b0, 4'd11);
    expCnt++;
    fetchDecode("bne2", 6'h05);
    applyStimulus("bneTaken", 1'b0, 6'h05, 1'b0, 1'b0, 4'd11);
    expCnt++;

    // Fetch timeout after four wait cycles, then Run restarts and clears Timeout
    for (int i = 0; i < 4; i++) applyStimulus("fetchStall", 1'b0, 6'h00, 1'b0, 1'b0, 4'd1);
    expTo = 1'b1;
    applyStimulus("timeoutIdle", 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    applyStimulus("timeoutRun", 1'b1, 6'h00, 1'b0, 1'b0, 4'd0);
    expTo = 1'b0;

    // JAL: illegal in the default build, jump-and-link when enabled
    fetchDecode("jal", 6'h03);
`ifdef MC_JUMP_EN
    applyStimulus("jalJump", 1'b0, 6'h03, 1'b0, 1'b0, 4'd12);
    expCnt++;
`else
    expIll = 1'b1;
    applyStimulus("jalIllegal", 1'b0, 6'h03, 1'b0, 1'b0, 4'd0);
    applyStimulus("idleNoRun", 1'b0, 6'h00, 1'b0, 1'b0, 4'd0);
    applyStimulus("illegalRun", 1'b1, 6'h00, 1'b0, 1'b0, 4'd0);
    expIll = 1'b0;
`endif
    applyStimulus("finalFetch", 1'b0, 6'h00, 1'b0, 1'b0, 4'd1);

    if (sbQ.size() > 0) begin
      $display("[TB] FAIL scoreboard: got %0d unchecked entries expected 0", sbQ.size());
      vectors++;
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
